// File: rtl/usb_phy_cfg_seq.sv
// usb_phy_cfg_seq: PHY power-up sequencer (POR hold, init-table APB writes, UTMI hold) then software APB pass-through; USB_PHY_CFG_TIMEOUT_EN adds an ACCESS timeout
module usb_phy_cfg_seq #(
  parameter int           POR_HOLD  = 16,
  parameter int           UTMI_HOLD = 32,
  parameter int           INIT_CNT  = 4,
  parameter logic [127:0] INIT_ADDR = '0,
  parameter logic [127:0] INIT_DATA = '0,
  parameter int           TIMEOUT   = 255
) (
  input  logic        pclk,
  input  logic        reset,
  output logic        phy_por,
  output logic        phy_utmi_reset,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        sw_req,
  input  logic        sw_write,
  input  logic [31:0] sw_addr,
  input  logic [31:0] sw_wdata,
  output logic        sw_ack,
  output logic [31:0] sw_rdata,
  output logic        sw_err,
  output logic        init_done
);
  localparam int MAXH = POR_HOLD > UTMI_HOLD ? POR_HOLD : UTMI_HOLD;
  localparam int CW = $clog2(MAXH + 1) + 1;
  typedef enum logic [2:0] {POR_WAIT, INIT_SETUP, INIT_ACCESS, UTMI_WAIT, IDLE, SW_SETUP, SW_ACCESS} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          hold_last, in_access, timed_out, xfer_done;
  assign in_access = state_q == INIT_ACCESS || state_q == SW_ACCESS;
  assign hold_last = state_q == POR_WAIT ? (POR_HOLD <= 1 || cnt_q == CW'(POR_HOLD - 1))
                                         : (UTMI_HOLD <= 1 || cnt_q == CW'(UTMI_HOLD - 1));
  assign xfer_done = in_access && (m_pready || timed_out);
  assign phy_por = state_q == POR_WAIT;
  assign phy_utmi_reset = !done_q;
  assign init_done = done_q;
  assign sw_rdata = sw_ack ? rdata_d : rdata_q;
`ifdef USB_PHY_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 2);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  assign timed_out = in_access && !m_pready && (TIMEOUT <= 1 || wcnt_q == TW'(TIMEOUT - 1));
  assign wcnt_d = in_access && !xfer_done ? wcnt_q + TW'(1) : '0;
  assign err_d = err_q | (state_q == INIT_ACCESS && timed_out);
  assign sw_err = sw_ack && (timed_out || err_q);
  // ACCESS wait counter and sticky init-timeout flag
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign timed_out = 1'b0;
  assign sw_err = 1'b0;
`endif
  // sequencer state, hold counter, init index, sticky done and captured read data
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      state_q <= POR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  // next state and APB master drive; address/data stay 0 while psel is low
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    idx_d     = idx_q;
    done_d    = done_q;
    rdata_d   = rdata_q;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    m_pwrite  = 1'b0;
    m_paddr   = '0;
    m_pwdata  = '0;
    sw_ack    = 1'b0;
    case (state_q)
      POR_WAIT, UTMI_WAIT: begin
        cnt_d = hold_last ? '0 : cnt_q + CW'(1);
        if (hold_last) begin
          state_d = state_q == UTMI_WAIT ? IDLE : (INIT_CNT > 0 ? INIT_SETUP : UTMI_WAIT);
          done_d  = done_q | (state_q == UTMI_WAIT);
        end
      end
      INIT_SETUP, INIT_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = state_q == INIT_ACCESS;
        m_pwrite  = 1'b1;
        m_paddr   = INIT_ADDR[{idx_q, 5'd0} +: 32];
        m_pwdata  = INIT_DATA[{idx_q, 5'd0} +: 32];
        if (state_q == INIT_SETUP) state_d = INIT_ACCESS;
        else if (xfer_done) begin
          idx_d   = idx_q + 2'd1;
          state_d = idx_q == 2'(INIT_CNT - 1) ? UTMI_WAIT : INIT_SETUP;
        end
      end
      IDLE: state_d = sw_req ? SW_SETUP : IDLE;
      SW_SETUP, SW_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = state_q == SW_ACCESS;
        m_pwrite  = sw_write;
        m_paddr   = sw_addr;
        m_pwdata  = sw_wdata;
        if (state_q == SW_SETUP) state_d = SW_ACCESS;
        else if (xfer_done) begin
          sw_ack  = 1'b1;
          rdata_d = sw_write || timed_out ? 32'h0 : m_prdata;
          state_d = IDLE;
        end
      end
      default: state_d = POR_WAIT;
    endcase
  end
endmodule

// File: doc/usb_phy_cfg_seq.md
USB_PHY_CFG_SEQ -- requirements
Module: usb_phy_cfg_seq

Interface
REQ-001 SHALL have parameter POR_HOLD, default 16, cycles phy_por stays asserted after reset release.
REQ-002 SHALL have parameter UTMI_HOLD, default 32, cycles phy_utmi_reset stays asserted after the init table completes.
REQ-003 SHALL have parameter INIT_CNT, default 4, range 0..4, number of init-table APB writes.
REQ-004 SHALL have parameters INIT_ADDR and INIT_DATA, each 128 bits, default 0; entry i occupies bits [32i+31:32i].
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum m_pready wait in cycles.
REQ-006 pclk  in  1  sole clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 phy_por  out  1  PHY power-on reset.
REQ-009 phy_utmi_reset  out  1  PHY UTMI port reset.
REQ-010 m_psel, m_penable, m_pwrite  out  1 each  APB master controls to the PHY.
REQ-011 m_paddr, m_pwdata  out  32 each  APB master address and write data.
REQ-012 m_prdata  in  32, m_pready  in  1  PHY APB read data and ready.
REQ-013 sw_req  in  1, sw_write  in  1, sw_addr  in  32, sw_wdata  in  32  software access request; held stable until sw_ack.
REQ-014 sw_ack  out  1, sw_rdata  out  32, sw_err  out  1  single-cycle completion pulse, read data, error flag.
REQ-015 init_done  out  1  high once sequencing is complete; sticky until reset.

Function
REQ-016 States SHALL be POR_WAIT, INIT_SETUP, INIT_ACCESS, UTMI_WAIT, IDLE, SW_SETUP, SW_ACCESS.
REQ-017 POR_WAIT: phy_por=1 for POR_HOLD cycles; then -> INIT_SETUP if INIT_CNT>0, else -> UTMI_WAIT.
REQ-018 Each APB transfer SHALL be a SETUP cycle (psel=1, penable=0) followed by ACCESS cycles (psel=1, penable=1) until m_pready=1; minimum 2 cycles.
REQ-019 Init writes SHALL be issued in order, entry 0 through INIT_CNT-1, with m_pwrite=1; after the last one completes -> UTMI_WAIT.
REQ-020 UTMI_WAIT: phy_utmi_reset=1 for UTMI_HOLD cycles, then -> IDLE; init_done SHALL rise on the IDLE entry cycle.
REQ-021 phy_utmi_reset SHALL be 1 in every state before IDLE and 0 from IDLE onward; phy_por SHALL be 0 from INIT_SETUP onward.
REQ-022 sw_req SHALL be ignored (no sw_ack) before init_done; the pending request is served once IDLE is reached.
REQ-023 IDLE with sw_req=1 -> SW_SETUP, presenting sw_addr, sw_wdata and sw_write on the master port.
REQ-024 SW_ACCESS completion cycle: sw_ack=1 for one cycle, sw_rdata=m_prdata captured (0 for writes), state -> IDLE.
REQ-025 Back-to-back requests: at least one IDLE cycle SHALL separate transfers; minimum software latency is sw_req to sw_ack in 3 cycles.
REQ-026 m_paddr and m_pwdata SHALL be 0 whenever m_psel=0.
REQ-027 Hold counters SHALL be wide enough for the parameter values and SHALL NOT wrap; POR_HOLD or UTMI_HOLD of 0 means a single cycle in that state.

Reset
REQ-028 On reset assertion, the block SHALL go immediately to POR_WAIT with phy_por=1 and phy_utmi_reset=1; all other outputs are 0, including init_done and counters.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer (psel drops asynchronously) and restart the full sequence when reset is released.

Configuration
REQ-030 USB_PHY_CFG_TIMEOUT_EN defined: a wait counter runs during ACCESS. When it reaches TIMEOUT without m_pready, the transfer SHALL terminate. For a software access, sw_ack=1, sw_err=1 and sw_rdata=0 are returned. For an init access, the sequencer SHALL skip to the next entry and set an internal sticky error that drives sw_err=1 on every later sw_ack.
REQ-031 USB_PHY_CFG_TIMEOUT_EN undefined: there SHALL be no counter, ACCESS waits indefinitely, and sw_err is tied to 0.

Verification
REQ-032 Defaults, m_pready always 1: phy_por is high for 16 cycles; 4 writes match INIT_ADDR/INIT_DATA in order; phy_utmi_reset is high for 32 more cycles; init_done=1.
REQ-033 After init, a read of 0x10 with m_prdata=0xA5A5_0001 and m_pready delayed 3 cycles gives sw_ack after 5 ACCESS/SETUP cycles total and sw_rdata=0xA5A5_0001.
REQ-034 sw_req held high from reset gives no sw_ack until init_done; the first transfer follows the IDLE cycle.
REQ-035 Reset pulsed during the 2nd init write ACCESS: psel goes to 0 at once; after release the sequence restarts with entry 0.
REQ-036 With USB_PHY_CFG_TIMEOUT_EN, TIMEOUT=8, m_pready stuck at 0: a software write acks with sw_err=1 after 8 ACCESS cycles. Without the macro, the bus remains in ACCESS with no ack.
